// File: rtl/spi_miso_transmitter.sv
// SPI mode-0 slave MISO serialiser: one-byte holding register (valid/ready) feeding
// an MSB-first shift register. cs/sck are oversampled so everything runs on `clock`.
module spi_miso_transmitter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       sck,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       byte_done,
  output logic       underrun,
  output logic       aborted,
  output logic       active
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic [SYNC_STAGES:0]   warmup_q;

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_valid_q, hold_valid_d;
  logic       byte_done_q, byte_done_d;
  logic       underrun_q, underrun_d;
  logic       aborted_q, aborted_d;

  logic cs_s, sck_s, sync_ok;
  logic cs_fall, cs_rise, sck_rise, sck_fall;
  logic load, accept;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      warmup_q   <= '0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      warmup_q   <= {warmup_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];

  // The idle values forced by reset are not real pin samples; a cs that is already
  // low at reset release must not look like a fresh falling edge, so starts wait
  // until both cs_s and cs_prev_q carry genuine samples.
  assign sync_ok  = warmup_q[SYNC_STAGES];
  assign cs_fall  = sync_ok & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  assign accept = tx_valid & ~hold_valid_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    byte_done_d  = 1'b0;
    underrun_d   = 1'b0;
    aborted_d    = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd0;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        // cs has priority; an sck edge landing in the same cycle is dropped.
        if (cs_rise) begin
          state_d   = IDLE;
          aborted_d = (bit_cnt_q != 3'd0);
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end else if (sck_rise) begin
          bit_cnt_d   = bit_cnt_q + 3'd1;
          byte_done_d = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            load = 1'b1;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (hold_valid_q) begin
        shift_d      = hold_data_q;
        hold_valid_d = 1'b0;
      end else begin
        shift_d    = FILL_BYTE;
        underrun_d = 1'b1;
      end
    end

    // No bypass: a byte arriving alongside a load waits in the holding register.
    if (accept) begin
      hold_data_d  = tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      byte_done_q  <= 1'b0;
      underrun_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      byte_done_q  <= byte_done_d;
      underrun_q   <= underrun_d;
      aborted_q    <= aborted_d;
    end
  end

  assign miso      = (state_q == SHIFT) & shift_q[7];
  assign active    = (state_q == SHIFT);
  assign tx_ready  = ~hold_valid_q;
  assign byte_done = byte_done_q;
  assign underrun  = underrun_q;
  assign aborted   = aborted_q;

endmodule

// File: doc/spi_miso_transmitter.md
Name: spi_miso_transmitter

Overview:
SPI mode-0 slave transmitter that drives MISO back to the MCU while the MCU clocks command bytes in on MOSI. It runs alongside the SPI receive path on the same cs/sck pins. It serialises status/readback bytes MSB-first from a one-byte holding register fed by a valid/ready handshake on the system clock. cs and sck are oversampled through synchronisers, so all logic is in the single `clock` domain.

Parameters:
SYNC_STAGES, 2, synchroniser flops on cs and sck (minimum 2)
FILL_BYTE, 8'h00, byte shifted out when no data is queued at a byte boundary

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
cs  input  1  SPI chip select, active low, asynchronous to clock
sck  input  1  SPI serial clock, asynchronous to clock
miso  output  1  serial data to master, MSB first
tx_data  input  8  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; accept when tx_valid && tx_ready
byte_done  output  1  one-cycle pulse: 8th rising sck of a byte seen
underrun  output  1  one-cycle pulse: FILL_BYTE loaded because holding register empty
aborted  output  1  one-cycle pulse: cs deasserted mid-byte
active  output  1  transaction in progress (synchronised cs low)

Behaviour:
Reset is synchronous and active-low, with one clock and no other reset source. While reset_n=0 on a rising clock edge:
- miso=0, byte_done=0, underrun=0, aborted=0, active=0.
- Holding register is emptied, so tx_ready=1 from the first cycle after reset.
- Shift register=0, bit_cnt=0.
- Synchroniser flops and edge-detect registers are set to the idle levels cs=1, sck=0.

Synchronisation:
- cs and sck each pass through SYNC_STAGES flops, plus one previous-value register for edge detection.
- Pin-to-action latency is SYNC_STAGES+1 clocks.
- Operating constraint: f_clock >= 2*(SYNC_STAGES+2)*f_sck.

Holding register:
- tx_ready = !hold_valid.
- A byte is accepted on a cycle with tx_valid && tx_ready; hold_valid is set the next cycle.
- hold_valid clears the cycle after a load consumes the byte.
- No bypass: a byte accepted in the same cycle as a load goes to the holding register, and that load uses FILL_BYTE.

States: IDLE, SHIFT.
- IDLE -> SHIFT on synchronised cs falling edge:
  - Load shift register from holding register if hold_valid, else load FILL_BYTE and pulse underrun.
  - bit_cnt=0, active=1.
- SHIFT, sck rising edge (master samples):
  - bit_cnt = bit_cnt+1 mod 8.
  - On the 7->0 wrap, pulse byte_done.
- SHIFT, sck falling edge:
  - If bit_cnt==0, load the next byte (holding or FILL_BYTE, underrun as above).
  - Otherwise shift left by one, bit 0 filled with 0.
- miso = shift[7] combinationally from the register at all times in SHIFT; miso=0 in IDLE.
- SHIFT -> IDLE on synchronised cs rising edge:
  - If bit_cnt!=0, pulse aborted and discard the partial byte; no byte_done.
  - bit_cnt=0, active=0, miso=0.
  - Holding register contents are retained.
- sck edges while in IDLE are ignored.
- A cs edge and an sck edge detected in the same cycle: the cs edge wins and the sck edge is dropped.
- The falling sck after the last bit of a transaction loads the next byte. If cs then rises with bit_cnt==0, that byte is lost, with no aborted pulse and no restore. Software sends bytes only on command responses.
- Reset mid-transaction: returns to IDLE with reset values. The next transaction starts only on a fresh cs falling edge seen after reset release.

Test Plan:
1. Queue 8'hA5, then cs low and 8 sck cycles at clock/16 -> MSB is valid on miso before the first rising sck. Master samples 1,0,1,0,0,1,0,1. byte_done pulses once after the 8th rise. tx_ready=1 after the load.
2. Queue 8'h3C; start transfer; queue 8'hC3 during bit 3; clock 16 bits -> master reads 8'h3C then 8'hC3, two byte_done pulses, underrun never asserted.
3. Holding register empty at cs fall, FILL_BYTE=8'h00 -> master reads 8'h00, underrun pulses exactly once at cs fall. A byte queued mid-transfer is sent as byte 2.
4. cs rises after 3 sck rising edges of 8'hFF -> aborted pulses once, no byte_done, active=0, miso=0. Next transaction starts a fresh byte from the holding register.
5. tx_valid held high with 8'h11 and 8'h22 back-to-back -> 8'h11 accepted, tx_ready=0 until the cs-fall load, then 8'h22 accepted. Master reads 8'h11, 8'h22.
6. Assert reset_n=0 for 1 cycle at bit 5 of a byte -> next cycle all outputs are at reset values and tx_ready=1. sck toggles before a new cs fall produce no miso activity.
